// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_pkg
// Description : Shared types and default sizes for the CPU/IO RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arbiter_pkg;

    localparam int c_ADDR_W       = 10;
    localparam int c_DATA_W       = 32;
    localparam int c_STARVE_MAX   = 4;
    localparam int c_STARVE_CNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ACC_CPU  = 3'd1,
        S_ACC_IO   = 3'd2,
        S_RESP_CPU = 3'd3,
        S_RESP_IO  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_starve_counter.sv
`default_nettype none
// ============================================================================
// Module      : starve_counter
// Description : Saturating count of consecutive IO arbitration losses.
// Revision    : 1.0 - initial release
// ============================================================================
module starve_counter
    import ram_arbiter_pkg::*;
#(
    parameter int MAX   = c_STARVE_MAX,
    parameter int CNT_W = c_STARVE_CNT_W
) (
    input  logic CLK,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [CNT_W-1:0] c_MAX = CNT_W'(MAX);

    logic [CNT_W-1:0] r_count;
    logic             w_sat;

    assign w_sat = (r_count >= c_MAX);
    assign sat   = w_sat;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && !w_sat) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Two-requester (CPU/IO) arbiter for one synchronous RAM port.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = c_ADDR_W,
    parameter int DATA_W     = c_DATA_W,
    parameter int STARVE_MAX = c_STARVE_MAX
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_gnt,
    output logic              io_rvalid,
    output logic [DATA_W-1:0] io_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_io_rdata;
    logic              w_idle;
    logic              w_sat;
    logic              w_cpu_win;
    logic              w_io_win;
    logic              w_inc;
    logic              w_clr;

    // Starved IO overrides CPU priority once the loss count saturates.
    assign w_idle    = (r_state == S_IDLE);
    assign w_cpu_win = cpu_req & ~(io_req & w_sat);
    assign w_io_win  = io_req & ~w_cpu_win;
    assign w_inc     = w_idle & io_req & w_cpu_win;
    assign w_clr     = w_idle & (w_io_win | ~io_req);

    starve_counter #(
        .MAX   (STARVE_MAX),
        .CNT_W (c_STARVE_CNT_W)
    ) u_starve (
        .CLK   (CLK),
        .reset (reset),
        .inc   (w_inc),
        .clr   (w_clr),
        .sat   (w_sat)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_io_rdata  <= '0;
        end else begin
            r_state <= w_next;
            if (w_idle && w_cpu_win) begin
                r_addr  <= cpu_addr;
                r_we    <= cpu_we;
                r_wdata <= cpu_wdata;
            end else if (w_idle && w_io_win) begin
                r_addr  <= io_addr;
                r_we    <= io_we;
                r_wdata <= io_wdata;
            end
            if (r_state == S_RESP_CPU) r_cpu_rdata <= ram_rdata;
            if (r_state == S_RESP_IO)  r_io_rdata  <= ram_rdata;
        end
    end

    always_comb begin
        w_next     = r_state;
        cpu_gnt    = 1'b0;
        cpu_rvalid = 1'b0;
        cpu_rdata  = r_cpu_rdata;
        io_gnt     = 1'b0;
        io_rvalid  = 1'b0;
        io_rdata   = r_io_rdata;
        ram_addr   = r_addr;
        ram_wdata  = r_wdata;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cpu_win)     w_next = S_ACC_CPU;
                else if (w_io_win) w_next = S_ACC_IO;
            end
            S_ACC_CPU: begin
                cpu_gnt = 1'b1;
                ram_we  = r_we;
                ram_re  = ~r_we;
                w_next  = r_we ? S_IDLE : S_RESP_CPU;
            end
            S_ACC_IO: begin
                io_gnt = 1'b1;
                ram_we = r_we;
                ram_re = ~r_we;
                w_next = r_we ? S_IDLE : S_RESP_IO;
            end
            S_RESP_CPU: begin
                cpu_rvalid = 1'b1;
                cpu_rdata  = ram_rdata;
                w_next     = S_IDLE;
            end
            S_RESP_IO: begin
                io_rvalid = 1'b1;
                io_rdata  = ram_rdata;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Stall is gated by reset so every output reads zero while reset is low.
    assign cpu_stall = reset & cpu_req
                     & ~(((r_state == S_ACC_CPU) & r_we) | (r_state == S_RESP_CPU));

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Directed and random checks of ram_arbiter with a RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    logic        CLK;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_stall;
    logic [9:0]  cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        io_req, io_we, io_gnt, io_rvalid;
    logic [9:0]  io_addr;
    logic [31:0] io_wdata, io_rdata;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic        ram_we, ram_re;

    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] cpu_q[$];
    logic [31:0] io_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    ram_arbiter dut (
        .CLK(CLK), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_rdata(io_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
        .ram_rdata(ram_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous RAM: read data appears one cycle after ram_re.
    always @(posedge CLK) begin
        if (ram_re) ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] = ram_wdata;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: reference memory updated in grant order, expected reads queued.
    always @(negedge CLK) begin
        if (reset) begin
            check("two_gnt", cpu_gnt & io_gnt, 0);
            check("we_and_re", ram_we & ram_re, 0);
            check("two_rvalid", cpu_rvalid & io_rvalid, 0);
            if (cpu_gnt) begin
                if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
                else        cpu_q.push_back(ref_mem[cpu_addr]);
            end
            if (io_gnt) begin
                if (io_we) ref_mem[io_addr] = io_wdata;
                else       io_q.push_back(ref_mem[io_addr]);
            end
            if (cpu_rvalid) begin
                if (cpu_q.size() == 0) check("cpu_dup_rvalid", cpu_rvalid, 0);
                else                   check("cpu_rdata", cpu_rdata, cpu_q.pop_front());
            end
            if (io_rvalid) begin
                if (io_q.size() == 0) check("io_dup_rvalid", io_rvalid, 0);
                else                  check("io_rdata", io_rdata, io_q.pop_front());
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, {cpu_gnt, cpu_rvalid, cpu_stall, io_gnt, io_rvalid, ram_we, ram_re}, 0);
        check({tag, "_cpu_rdata"}, cpu_rdata, 0);
        check({tag, "_io_rdata"}, io_rdata, 0);
        check({tag, "_ram_addr"}, ram_addr, 0);
        check({tag, "_ram_wdata"}, ram_wdata, 0);
    endtask

    task automatic cpu_access(input logic we, input logic [9:0] a, input logic [31:0] d);
        int n;
        @(posedge CLK); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        n = 0;
        do begin @(negedge CLK); n++; end while (!cpu_gnt && n < 64);
        if (!cpu_gnt) check("cpu_gnt_timeout", cpu_gnt, 1);
        cpu_req = 1'b0;
    endtask

    task automatic io_access(input logic we, input logic [9:0] a, input logic [31:0] d);
        int n;
        @(posedge CLK); #1;
        io_req = 1'b1; io_we = we; io_addr = a; io_wdata = d;
        n = 0;
        do begin @(negedge CLK); n++; end while (!io_gnt && n < 64);
        if (!io_gnt) check("io_gnt_timeout", io_gnt, 1);
        io_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          ncpu;
        logic [5:0]  seq;
        logic        saw_io;

        for (int i = 0; i < 1024; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        mem[5] = 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;
        reset = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        io_req = 0; io_we = 0; io_addr = '0; io_wdata = '0;
        #1;
        check_outputs_zero("reset");
        check("reset_starve", dut.u_starve.r_count, 0);
        repeat (2) @(posedge CLK);
        #1 reset = 1'b1;

        // Uncontended CPU read latency.
        @(negedge CLK);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
        #1 check("r30_stall_idle", cpu_stall, 1);
        @(negedge CLK);
        check("r30_gnt", cpu_gnt, 1);
        check("r30_stall_acc", cpu_stall, 1);
        check("r30_no_rvalid_acc", cpu_rvalid, 0);
        @(negedge CLK);
        check("r30_gnt_one_cycle", cpu_gnt, 0);
        check("r30_rvalid", cpu_rvalid, 1);
        check("r30_rdata", cpu_rdata, 32'hDEADBEEF);
        check("r30_stall_resp", cpu_stall, 0);
        cpu_req = 1'b0;
        @(negedge CLK);
        check("r30_rvalid_single", cpu_rvalid, 0);
        check("r30_rdata_hold", cpu_rdata, 32'hDEADBEEF);

        // Simultaneous CPU write / IO read, same address.
        repeat (2) @(negedge CLK);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h3FF; cpu_wdata = 32'h12345678;
        io_req = 1'b1; io_we = 1'b0; io_addr = 10'h3FF;
        @(negedge CLK);
        check("r31_cpu_first", {cpu_gnt, io_gnt}, 2'b10);
        cpu_req = 1'b0;
        n = 0;
        do begin @(negedge CLK); n++; end while (!io_gnt && n < 16);
        check("r31_io_gnt", io_gnt, 1);
        check("r31_io_gnt_latency", n, 2);
        io_req = 1'b0;
        @(negedge CLK);
        check("r31_io_rvalid", io_rvalid, 1);
        check("r31_io_rdata", io_rdata, 32'h12345678);

        // Starvation override with CPU requesting continuously.
        repeat (2) @(negedge CLK);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h010; cpu_wdata = 32'hA5A50000;
        io_req = 1'b1; io_we = 1'b0; io_addr = 10'h010;
        seq = '0; ncpu = 0; n = 0;
        while (ncpu < 6 && n < 80) begin
            @(negedge CLK); n++;
            if (cpu_gnt) ncpu++;
            if (io_gnt) begin
                seq[ncpu] = 1'b1;
                ncpu++;
                io_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        check("r32_grant_count", ncpu, 6);
        check("r32_grant_order", seq, 6'b010000);

        // IO request dropped just before it would win.
        repeat (4) @(negedge CLK);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h020; cpu_wdata = 32'h0BADF00D;
        io_req = 1'b1; io_we = 1'b0; io_addr = 10'h030;
        ncpu = 0; n = 0; saw_io = 1'b0;
        while (ncpu < 8 && n < 80) begin
            @(negedge CLK); n++;
            if (io_gnt) saw_io = 1'b1;
            if (cpu_gnt) begin
                ncpu++;
                if (ncpu == 4) begin
                    check("r34_starve_sat", dut.u_starve.r_count, 4);
                    io_req = 1'b0;
                end
            end
        end
        cpu_req = 1'b0;
        check("r34_cpu_grants", ncpu, 8);
        check("r34_no_io_gnt", saw_io, 0);
        check("r34_starve_clear", dut.u_starve.r_count, 0);

        // Reset asserted during an IO read response.
        repeat (2) @(negedge CLK);
        io_req = 1'b1; io_we = 1'b0; io_addr = 10'h3FF;
        n = 0;
        do begin @(negedge CLK); n++; end while (!io_gnt && n < 16);
        check("r33_io_gnt", io_gnt, 1);
        io_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
        @(posedge CLK); #2 reset = 1'b0;
        #1 check_outputs_zero("r33");
        check("r33_state", dut.r_state, S_IDLE);
        io_q.delete();
        repeat (2) @(posedge CLK);
        #3 reset = 1'b1;
        check("r33_idle_after", dut.r_state, S_IDLE);
        @(negedge CLK);
        check("r27_no_gnt_before_edge", cpu_gnt, 0);
        @(negedge CLK);
        check("r27_first_edge_arb", cpu_gnt, 1);
        cpu_req = 1'b0;
        repeat (3) @(negedge CLK);

        // Random mixed stream from both requesters.
        fork
            begin
                for (int i = 0; i < 500; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge CLK);
                    cpu_access(1'($urandom_range(0, 1)), 10'($urandom_range(0, 7)), $urandom);
                end
            end
            begin
                for (int j = 0; j < 500; j++) begin
                    repeat ($urandom_range(0, 3)) @(posedge CLK);
                    io_access(1'($urandom_range(0, 1)), 10'($urandom_range(0, 7)), $urandom);
                end
            end
        join
        repeat (6) @(negedge CLK);
        check("cpu_lost_rvalid", cpu_q.size(), 0);
        check("io_lost_rvalid", io_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 10, RAM word-address width.
REQ-002 SHALL have parameter DATA_W, 32, data width.
REQ-003 SHALL have parameter STARVE_MAX, 4, consecutive IO losses before IO is forced a grant (range 1..15).
REQ-004 SHALL have port CLK  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports cpu_req/cpu_we  in  1 each  CPU access request / write qualifier.
REQ-007 SHALL have ports cpu_addr  in  ADDR_W, and cpu_wdata  in  DATA_W, for CPU address / store data.
REQ-008 SHALL have ports cpu_gnt, cpu_rvalid  out  1, and cpu_rdata  out  DATA_W, for CPU grant pulse / read-valid pulse / load data.
REQ-009 SHALL have ports cpu_stall  out  1  holds the CPU clock enable off while its access is incomplete.
REQ-010 SHALL have ports io_req, io_we, io_addr, io_wdata, io_gnt, io_rvalid, io_rdata with the same directions and widths as the CPU set, for the IO/display requester.
REQ-011 SHALL have ports ram_addr  out  ADDR_W, ram_wdata  out  DATA_W, ram_we/ram_re  out  1, and ram_rdata  in  DATA_W, forming the single shared synchronous RAM port (read data valid one cycle after ram_re).

Function
REQ-012 SHALL implement FSM states IDLE, ACC_CPU, ACC_IO, RESP_CPU, RESP_IO.
REQ-013 SHALL arbitrate only in IDLE: CPU wins if cpu_req=1, unless io_req=1 and starve_cnt==STARVE_MAX, in which case IO wins; IO wins if only io_req=1; otherwise stay IDLE.
REQ-014 SHALL on the winning edge latch req's addr/we/wdata and enter ACC_x; requesters hold req, addr, we, wdata stable until their gnt.
REQ-015 SHALL in ACC_x assert x_gnt for exactly one cycle and drive ram_addr/ram_wdata from the latch, with ram_we=latched we and ram_re=~latched we.
REQ-016 SHALL go ACC_x -> IDLE for writes, and ACC_x -> RESP_x for reads.
REQ-017 SHALL in RESP_x assert x_rvalid for one cycle with x_rdata=ram_rdata, then go to IDLE; the rdata outputs hold their last value otherwise.
REQ-018 SHALL meet latency for an uncontended access seen in IDLE at edge N: gnt in cycle N+1; read rvalid in cycle N+2; next arbitration at edge N+2 (write) or N+3 (read).
REQ-019 SHALL increment starve_cnt (saturating at STARVE_MAX) at each IDLE arbitration where io_req=1 and CPU wins; clear it when IO is granted or io_req=0 in IDLE.
REQ-020 SHALL assert cpu_stall = cpu_req AND NOT (cpu write in ACC_CPU OR RESP_CPU).
REQ-021 SHALL drive ram_we=ram_re=0, gnt=0, and rvalid=0 in IDLE and in the other requester's states.
REQ-022 SHALL ignore a req dropped before grant; no gnt is issued and starve_cnt is cleared if it was io_req.
REQ-023 SHALL complete an access whose req drops after gnt normally, including RESP.
REQ-024 SHALL serialize same-address simultaneous requests: the winner completes fully before the loser is granted, so the loser's read sees the winner's write.
REQ-025 SHALL never assert ram_we and ram_re together, nor both gnts or both rvalids in one cycle.

Reset
REQ-026 SHALL on reset=0 immediately force state=IDLE, starve_cnt=0, latch=0, and all outputs 0 (ram_we deasserted asynchronously), aborting any access in progress; no rvalid is issued for an aborted read.
REQ-027 SHALL arbitrate first at the first rising edge after reset returns to 1.

Structure
REQ-028 SHALL place the state enumeration, ADDR_W/DATA_W defaults and STARVE_MAX default in shared package ram_arbiter_pkg.
REQ-029 SHALL implement the saturating starvation counter as sub-module starve_counter (inc, clr, sat flag).

Verification
REQ-030 SHALL test uncontended CPU read of addr 0x005 holding 0xDEADBEEF -> cpu_gnt at N+1, cpu_rvalid at N+2 with cpu_rdata=0xDEADBEEF, cpu_stall high from N through N+1.
REQ-031 SHALL test simultaneous CPU write 0x12345678 and IO read at addr 0x3FF -> CPU granted first; IO rvalid returns 0x12345678.
REQ-032 SHALL test CPU requesting continuously with io_req held and STARVE_MAX=4 -> io_gnt on the 5th arbitration, then CPU regains priority.
REQ-033 SHALL test reset pulled low during RESP_IO -> io_rvalid never asserted, all outputs 0 within the same cycle, IDLE after release.
REQ-034 SHALL test io_req dropped two cycles before IO would win -> no io_gnt and starve_cnt=0.
REQ-035 SHALL check, on a random mixed stream of 1000 requests, that no cycle has both gnts, ram_we&ram_re, or lost/duplicated rvalid.
